// File: rtl/image_pixel_port.sv
// Pixel-addressed image store: maps (x, y) to a packed word and byte lane, serves
// one unpacked pixel per request through a two-stage valid/ready pipeline.
module image_pixel_port #(
  parameter int                  IMG_W     = 300,
  parameter int                  IMG_H     = 300,
  parameter int                  PIX_BITS  = 8,
  parameter int                  WORD_BITS = 32,
  parameter string               INIT_FILE = "tessia.dat",
  parameter logic [PIX_BITS-1:0] BG_VALUE  = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [$clog2(IMG_W+1)-1:0]   req_x,
  input  logic [$clog2(IMG_H+1)-1:0]   req_y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PIX_BITS-1:0]          out_pixel,
  output logic                         out_oor,
  input  logic                         wr_en,
  input  logic [$clog2(IMG_W+1)-1:0]   wr_x,
  input  logic [$clog2(IMG_H+1)-1:0]   wr_y,
  input  logic [PIX_BITS-1:0]          wr_pixel
);

  localparam int PPW   = WORD_BITS / PIX_BITS;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int DEPTH = (NPIX + PPW - 1) / PPW;
  localparam int XW    = $clog2(IMG_W + 1);
  localparam int YW    = $clog2(IMG_H + 1);
  localparam int PW    = $clog2(NPIX + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW    = (PPW > 1) ? $clog2(PPW) : 1;

  function automatic logic [PW-1:0] pix_index(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return PW'(y) * PW'(IMG_W) + PW'(x);
  endfunction

  function automatic logic in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (x < XW'(IMG_W)) && (y < YW'(IMG_H));
  endfunction

  // Lane 0 sits in the most-significant slot so hex files read left to right.
  function automatic logic [PIX_BITS-1:0] lane_pick(input logic [WORD_BITS-1:0] w,
                                                    input logic [LW-1:0] l);
    return PIX_BITS'(w >> ((PPW - 1 - int'(l)) * PIX_BITS));
  endfunction

  logic [WORD_BITS-1:0] mem [DEPTH];

  logic [PW-1:0]        rd_p, wr_p;
  logic [AW-1:0]        rd_addr, wr_addr;
  logic [LW-1:0]        rd_lane, wr_lane;
  logic                 rd_ok, wr_ok;
  logic                 adv1, adv2;
  logic                 vld_p1;
  logic                 oor_p1;
  logic [LW-1:0]        lane_p1;
  logic [WORD_BITS-1:0] word_p1;

  assign rd_p    = pix_index(req_x, req_y);
  assign wr_p    = pix_index(wr_x, wr_y);
  assign rd_addr = AW'(rd_p / PW'(PPW));
  assign wr_addr = AW'(wr_p / PW'(PPW));
  assign rd_lane = LW'(rd_p % PW'(PPW));
  assign wr_lane = LW'(wr_p % PW'(PPW));
  assign rd_ok   = in_range(req_x, req_y);
  assign wr_ok   = in_range(wr_x, wr_y);

  assign adv2      = !out_valid || out_ready;
  assign adv1      = !vld_p1 || adv2;
  assign req_ready = adv1;

  // Stage 1: word read (old data on same-word write), lane and range flag
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      for (int i = 0; i < PPW; i++) begin
        if (wr_lane == LW'(PPW - 1 - i))
          mem[wr_addr][i*PIX_BITS +: PIX_BITS] <= wr_pixel;
      end
    end
    if (adv1 && req_valid && rd_ok)
      word_p1 <= mem[rd_addr];
    if (adv1) begin
      lane_p1 <= rd_lane;
      oor_p1  <= !rd_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vld_p1 <= 1'b0;
    else if (adv1)
      vld_p1 <= req_valid;
  end

  // Stage 2: lane select into the output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pixel <= BG_VALUE;
      out_oor   <= 1'b0;
    end else if (adv2) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_oor   <= oor_p1;
        out_pixel <= oor_p1 ? BG_VALUE : lane_pick(word_p1, lane_p1);
      end
    end
  end

endmodule

// File: tb/tb_image_pixel_port.sv
// Bench for image_pixel_port: scoreboard of accepted requests against a pixel-array
// model, plus directed sequences with literal expected pixels.
module tb_image_pixel_port;

  logic       clk, rst_n;
  logic       req_valid, req_ready;
  logic [8:0] req_x, req_y;
  logic       out_valid, out_ready;
  logic [7:0] out_pixel;
  logic       out_oor;
  logic       wr_en;
  logic [8:0] wr_x, wr_y;
  logic [7:0] wr_pixel;

  int checks = 0;
  int errors = 0;

  image_pixel_port #(
    .IMG_W(300), .IMG_H(300), .PIX_BITS(8), .WORD_BITS(32),
    .INIT_FILE(""), .BG_VALUE(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .out_oor(out_oor),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pixel array addressed by y*W+x, and the queue of responses owed.
  logic [7:0] mm [int];
  logic [8:0] sb_q [$];
  logic [8:0] lit_q [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      automatic bit mready = (sb_q.size() < 2) || out_ready;
      automatic int p = int'(req_y) * 300 + int'(req_x);
      if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
      if (req_valid && mready) begin
        if (req_x >= 300 || req_y >= 300) sb_q.push_back({1'b1, 8'h00});
        else sb_q.push_back({1'b0, mm.exists(p) ? mm[p] : 8'h00});
      end
      if (wr_en && wr_x < 300 && wr_y < 300)
        mm[int'(wr_y) * 300 + int'(wr_x)] = wr_pixel;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, (sb_q.size() < 2) || out_ready});
      if (out_valid) begin
        if (sb_q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
        else chk("sb_pixel", {23'b0, out_oor, out_pixel}, {23'b0, sb_q[0]});
      end
      if (out_valid && out_ready && lit_q.size() > 0)
        chk("lit_pixel", {23'b0, out_oor, out_pixel}, {23'b0, lit_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int x, input int y, input logic [7:0] v);
    wr_x = 9'(x); wr_y = 9'(y); wr_pixel = v; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  int acc_cnt = 0;

  task automatic send(input int x, input int y);
    int n = 0;
    bit done = 0;
    req_x = 9'(x); req_y = 9'(y); req_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = req_ready;
      tick();
      n++;
      if (!done && n > 50) begin
        chk("send_timeout", 32'd0, 32'd1);
        done = 1;
      end
    end
    acc_cnt++;
  endtask

  task automatic wait_lits();
    int n = 0;
    req_valid = 1'b0;
    while (lit_q.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    chk("lit_drain", lit_q.size(), 0);
    lit_q.delete();
    repeat (2) tick();
  endtask

  logic [7:0] row0 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0;
    out_ready = 1'b0; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_pixel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pixel", {24'b0, out_pixel}, 32'h00);
    chk("rst_out_oor", {31'b0, out_oor}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;

    for (int i = 0; i < 8; i++) wr(i, 0, row0[i]);
    for (int i = 0; i < 4; i++) wr(i, 5, 8'hA0 + 8'(i));
    wr(0, 6, 8'h66);
    wr(299, 299, 8'h5A);
    repeat (2) tick();

    // Back-to-back reads: first result two edges after presentation, then one per cycle
    req_x = 0; req_y = 0; req_valid = 1'b1;
    @(negedge clk); chk("lat_c0_valid", {31'b0, out_valid}, 32'd0);
    tick(); req_x = 3;
    @(negedge clk); chk("lat_c1_valid", {31'b0, out_valid}, 32'd0);
    tick(); req_x = 4;
    @(negedge clk); chk("t1_valid0", {31'b0, out_valid}, 32'd1);
    chk("t1_pix0", {23'b0, out_oor, out_pixel}, 32'h011);
    tick(); req_valid = 1'b0;
    @(negedge clk); chk("t1_valid1", {31'b0, out_valid}, 32'd1);
    chk("t1_pix1", {23'b0, out_oor, out_pixel}, 32'h044);
    tick();
    @(negedge clk); chk("t1_valid2", {31'b0, out_valid}, 32'd1);
    chk("t1_pix2", {23'b0, out_oor, out_pixel}, 32'h055);
    tick();
    @(negedge clk); chk("t1_idle", {31'b0, out_valid}, 32'd0);
    repeat (2) tick();

    // Corner pixel and out-of-range coordinates
    lit_q.push_back({1'b0, 8'h5A}); lit_q.push_back({1'b1, 8'h00}); lit_q.push_back({1'b1, 8'h00});
    send(299, 299); send(300, 0); send(0, 300);
    wait_lits();

    // Lane write with a same-cycle read of the same pixel (old value)
    wr_x = 1; wr_y = 0; wr_pixel = 8'hAB; wr_en = 1'b1;
    lit_q.push_back({1'b0, 8'h22});
    send(1, 0);
    wr_en = 1'b0;
    lit_q.push_back({1'b0, 8'h11}); lit_q.push_back({1'b0, 8'hAB});
    lit_q.push_back({1'b0, 8'h33}); lit_q.push_back({1'b0, 8'h44});
    for (int i = 0; i < 4; i++) send(i, 0);
    wait_lits();

    // Out-of-range write must not alias onto any in-range pixel
    wr(300, 5, 8'hEE);
    for (int i = 0; i < 4; i++) lit_q.push_back({1'b0, 8'hA0 + 8'(i)});
    lit_q.push_back({1'b0, 8'h66});
    for (int i = 0; i < 4; i++) send(i, 5);
    send(0, 6);
    wait_lits();

    // Backpressure: consumer stalls three cycles while four requests are offered
    acc_cnt = 0;
    lit_q.push_back({1'b0, 8'h11}); lit_q.push_back({1'b0, 8'hAB});
    lit_q.push_back({1'b0, 8'h33}); lit_q.push_back({1'b0, 8'h44});
    fork
      begin
        out_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("bp_ready_low", {31'b0, req_ready}, 32'd0);
        chk("bp_accepted", acc_cnt, 2);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_back", {31'b0, req_ready}, 32'd1);
      end
      begin
        for (int i = 0; i < 4; i++) send(i, 0);
        req_valid = 1'b0;
      end
    join
    wait_lits();

    // Asynchronous reset with two requests in flight
    send(4, 0); send(5, 0);
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale", {31'b0, out_valid}, 32'd0);
    end
    tick();
    lit_q.push_back({1'b0, 8'h44});
    send(3, 0);
    wait_lits();

    chk("sb_drain", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
